// File: rtl/pc_fetch_queue_pkg.sv
// Shared types and defaults for the instruction-fetch queue.
package pc_fetch_queue_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;
  localparam int unsigned PC_STEP      = 4;

  localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Queue entry at the default widths.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] data;
    logic                    exc;
  } fetch_entry_t;

  // Redirect request as produced by ID.
  typedef struct packed {
    logic                    en;
    logic [FETCH_ADDR_W-1:0] addr;
  } jump_t;

endpackage

// File: rtl/pc_fetch_queue_fetch_fifo.sv
// fetch_fifo: generic synchronous FIFO with push/pop/flush and occupancy count.
// DEPTH must be a power of two; flush wins over push and pop.
module pc_fetch_queue_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= push_data;
  end

  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = empty ? entry_t'('0) : mem[rd_ptr];

endmodule

// File: rtl/pc_fetch_queue.sv
// pc_fetch_queue: decoupled prefetcher. Owns the fetch PC, issues pipelined
// memory requests, buffers returned words in order and serves ID via valid/ready.
// Optional feature macro: IF_MISALIGN_EXC_EN (misaligned redirect raises an
// exception entry and halts fetch instead of silently aligning the target).
module pc_fetch_queue
  import pc_fetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       DATA_W   = FETCH_DATA_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_exc,
  input  logic              inst_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
    logic              exc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q,  resp_pc_d;
  logic [CNT_W-1:0]  outst_q,    outst_d;
  logic [CNT_W-1:0]  discard_q,  discard_d;
  logic              req_q,      req_d;
  logic              halt_q,     halt_d;
  logic              exc_pend_q, exc_pend_d;

  logic [CNT_W-1:0]  occ, occ_d;
  logic [SUM_W-1:0]  inflight_d;
  logic              fifo_empty;
  logic              push, pop, flush;
  entry_t            push_entry, head;

  logic              gnt_fire;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_misaligned;

  assign gnt_fire = req_q & mem_gnt;

`ifdef IF_MISALIGN_EXC_EN
  assign tgt            = redirect_addr;
  assign tgt_misaligned = |redirect_addr[1:0];
`else
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^redirect_addr[1:0];
  assign tgt             = {redirect_addr[ADDR_W-1:2], 2'b00};
  assign tgt_misaligned  = 1'b0;
`endif

  // Next-state: redirect/flush, response accept or discard, issue, request gating.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    halt_d     = halt_q;
    exc_pend_d = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    flush      = 1'b0;
    pop        = inst_valid & inst_ready;

    if (redirect_en) begin
      // Everything in flight, including this cycle's grant, becomes stale.
      flush      = 1'b1;
      fetch_pc_d = tgt;
      resp_pc_d  = tgt;
      outst_d    = outst_q + CNT_W'(gnt_fire) - CNT_W'(mem_rvalid);
      discard_d  = outst_d;
      halt_d     = tgt_misaligned;
      exc_pend_d = tgt_misaligned;
    end else begin
      if (mem_rvalid) begin
        outst_d = outst_d - CNT_W'(1);
        if (discard_q != '0) begin
          discard_d = discard_q - CNT_W'(1);
        end else begin
          push       = 1'b1;
          push_entry = '{pc: resp_pc_q, data: mem_rdata, exc: 1'b0};
          resp_pc_d  = resp_pc_q + ADDR_W'(PC_STEP);
        end
      end
      if (gnt_fire) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        outst_d    = outst_d + CNT_W'(1);
      end
      // All responses are being discarded here, so this never collides with a data push.
      if (exc_pend_q) begin
        push       = 1'b1;
        push_entry = '{pc: resp_pc_q, data: '0, exc: 1'b1};
      end
    end

    occ_d      = flush ? '0 : occ + CNT_W'(push) - CNT_W'(pop);
    inflight_d = SUM_W'(occ_d) + SUM_W'(outst_d);
    req_d      = !halt_d && (inflight_d < SUM_W'(DEPTH));
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      req_q      <= 1'b0;
      halt_q     <= 1'b0;
      exc_pend_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      req_q      <= req_d;
      halt_q     <= halt_d;
      exc_pend_q <= exc_pend_d;
    end
  end

  pc_fetch_queue_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (occ),
    .empty     (fifo_empty)
  );

  assign mem_req    = req_q;
  assign mem_addr   = fetch_pc_q;
  assign inst_valid = !fifo_empty;
  assign inst_pc    = head.pc;
  assign inst_data  = head.data;
  assign inst_exc   = head.exc;

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Self-checking bench for pc_fetch_queue: cycle table for start-up and
// back-pressure, directed redirect corner cases, and a randomized run
// against a queue-level reference model with a behavioural memory.
module tb_pc_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_exc;
  logic        inst_ready;

  always #5 clk = ~clk;

  pc_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .inst_valid    (inst_valid),
    .inst_pc       (inst_pc),
    .inst_data     (inst_data),
    .inst_exc      (inst_exc),
    .inst_ready    (inst_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } pend_t;

  typedef struct {
    bit          rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  int          n_vec, n_err, cyc;
  pend_t       pend[$];
  int          epoch, live_q, stale_seen, n_gnts, n_xfer;
  int          lat_min, lat_max;
  logic [31:0] exp_pc, last_gnt_addr, last_xfer_pc;
  bit          model_en;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] a);
`ifdef IF_MISALIGN_EXC_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: head must be the next sequential PC; occupancy bounded.
  task automatic check_model();
    cmp("inst_valid", 32'(inst_valid), 32'(live_q > 0));
    if (inst_valid) begin
      cmp("inst_pc", inst_pc, exp_pc);
      cmp("inst_data", inst_data, word_of(exp_pc));
      cmp("inst_exc", 32'(inst_exc), 32'd0);
    end
    cmp("occupancy_le_depth", 32'((pend.size() + live_q) <= DEPTH), 32'd1);
  endtask

  // One clock cycle: drive inputs, check, advance memory and reference model.
  task automatic step(input bit rdy, input bit gnt, input bit rv_ok,
                      input bit redir, input logic [31:0] raddr);
    bit    rv, gf, xf;
    pend_t e;
    inst_ready    = rdy;
    mem_gnt       = gnt;
    redirect_en   = redir;
    redirect_addr = raddr;
    rv            = rv_ok && pend.size() > 0 && pend[0].due <= cyc;
    mem_rvalid    = rv;
    mem_rdata     = rv ? word_of(pend[0].addr) : $urandom();
    #1;
    if (model_en) check_model();
    gf = mem_req && mem_gnt;
    xf = inst_valid && inst_ready;
    if (xf) begin
      n_xfer++;
      last_xfer_pc = inst_pc;
      if (live_q > 0) live_q--;
      exp_pc = exp_pc + 32'd4;
    end
    if (rv) begin
      e = pend.pop_front();
      if (!redir && e.epoch == epoch) live_q++;
      else stale_seen++;
    end
    if (gf) begin
      pend.push_back('{addr: mem_addr, due: cyc + int'($urandom_range(lat_max, lat_min)), epoch: epoch});
      n_gnts++;
      last_gnt_addr = mem_addr;
    end
    if (redir) begin
      epoch++;
      live_q = 0;
      exp_pc = tgt_of(raddr);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; inst_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; redirect_en = 1'b0; redirect_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst.mem_req", 32'(mem_req), 32'd0);
    cmp("rst.mem_addr", mem_addr, 32'h0);
    cmp("rst.inst_valid", 32'(inst_valid), 32'd0);
    cmp("rst.inst_pc", inst_pc, 32'h0);
    cmp("rst.inst_data", inst_data, 32'h0);
    cmp("rst.inst_exc", 32'(inst_exc), 32'd0);
    pend.delete();
    epoch = 0; live_q = 0; exp_pc = 32'h0; model_en = 1'b1;
    rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [10];
    int   g0, x0, exp_stale, done;
    bit   hit;
    logic [31:0] ra;

    n_vec = 0; n_err = 0; cyc = 0; stale_seen = 0; n_gnts = 0; n_xfer = 0;
    last_gnt_addr = '0; last_xfer_pc = '0;

    // Start-up with grant every cycle, latency 1; ready dropped for two cycles.
    tbl[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[2] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[6] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[7] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[8] = '{1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C};
    tbl[9] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cmp($sformatf("tbl%0d.mem_req", i), 32'(mem_req), 32'(tbl[i].exp_req));
      cmp($sformatf("tbl%0d.mem_addr", i), mem_addr, tbl[i].exp_addr);
      cmp($sformatf("tbl%0d.inst_valid", i), 32'(inst_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) cmp($sformatf("tbl%0d.inst_pc", i), inst_pc, tbl[i].exp_pc);
      step(tbl[i].rdy, 1'b1, 1'b1, 1'b0, 32'h0);
    end

    // Back-pressure: exactly DEPTH grants, then resume at 0x10 after draining.
    do_reset();
    n_gnts = 0;
    repeat (12) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cmp("full.grants", 32'(n_gnts), 32'(DEPTH));
    cmp("full.mem_req", 32'(mem_req), 32'd0);
    g0 = n_gnts;
    for (int i = 0; i < 20 && n_gnts == g0; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cmp("full.resume_granted", 32'(n_gnts > g0), 32'd1);
    cmp("full.resume_addr", last_gnt_addr, 32'h10);
    repeat (20) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect to 0x100 with three requests outstanding at latency 4.
    lat_min = 4; lat_max = 4;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (pend.size() == 3) begin
        stale_seen = 0;
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
        hit = 1'b1;
      end else begin
        step(1'b1, pend.size() < 3, 1'b1, 1'b0, 32'h0);
      end
    end
    cmp("redir3.reached", 32'(hit), 32'd1);
    x0 = n_xfer;
    for (int i = 0; i < 30 && n_xfer == x0; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cmp("redir3.stale_dropped", 32'(stale_seen), 32'd3);
    cmp("redir3.first_pc", last_xfer_pc, 32'h100);

    // Redirect coinciding with a grant and a response; target near address wrap.
    lat_min = 2; lat_max = 2;
    do_reset();
    hit = 1'b0; exp_stale = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (n_xfer > 0 && mem_req && pend.size() > 0 && pend[0].due <= cyc) begin
        exp_stale = pend.size() + 1;
        stale_seen = 0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        hit = 1'b1;
      end else begin
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      end
    end
    cmp("redirgr.reached", 32'(hit), 32'd1);
    x0 = n_xfer;
    for (int i = 0; i < 30 && n_xfer == x0; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cmp("redirgr.stale_dropped", 32'(stale_seen), 32'(exp_stale));
    cmp("redirgr.first_pc", last_xfer_pc, 32'hFFFF_FFF8);
    repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

`ifndef IF_MISALIGN_EXC_EN
    // Misaligned target is silently aligned.
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h102);
    x0 = n_xfer;
    for (int i = 0; i < 30 && n_xfer == x0; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cmp("misalign.first_pc", last_xfer_pc, 32'h100);
`endif

    // Randomized stalls, latencies and redirects: 1000 in-order instructions.
    lat_min = 1; lat_max = 5;
    do_reset();
    x0 = n_xfer; done = 0;
    for (int i = 0; i < 20000 && done == 0; i++) begin
      ra = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                   : ($urandom & 32'h0000_FFFF);
`ifdef IF_MISALIGN_EXC_EN
      ra = {ra[31:2], 2'b00};
`endif
      step($urandom_range(99) < 75, $urandom_range(99) < 80, $urandom_range(99) < 80,
           $urandom_range(99) < 2, ra);
      if (n_xfer - x0 >= 1000) done = 1;
    end
    cmp("random.1000_within_budget", 32'(done), 32'd1);

`ifdef IF_MISALIGN_EXC_EN
    // Misaligned redirect: one exception entry, fetch halted until next redirect.
    lat_min = 2; lat_max = 2;
    do_reset();
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    model_en = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h102);
    g0 = n_gnts;
    cmp("exc.flushed", 32'(inst_valid), 32'd0);
    cmp("exc.no_req", 32'(mem_req), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cmp("exc.valid", 32'(inst_valid), 32'd1);
    cmp("exc.pc", inst_pc, 32'h102);
    cmp("exc.flag", 32'(inst_exc), 32'd1);
    cmp("exc.data", inst_data, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      cmp("exc.halt_req", 32'(mem_req), 32'd0);
    end
    cmp("exc.halt_grants", 32'(n_gnts - g0), 32'd0);
    cmp("exc.held", inst_pc, 32'h102);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    model_en = 1'b1;
    x0 = n_xfer;
    for (int i = 0; i < 30 && n_xfer == x0; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cmp("exc.resume_pc", last_xfer_pc, 32'h200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
